// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor. The operation is split into STAGES ripple-carry
// chunks of WIDTH/STAGES bits, with one register stage per chunk and a valid flag carried alongside.
module add_pipe_nbit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  output logic [WIDTH-1:0] O,
  output logic             C,
  output logic             V
);

  localparam int CW = WIDTH / STAGES;

  // Subtraction becomes A + ~B + ~CI, so the chunks below only ever add.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = SUB ? ~B : B;
  assign cin_eff = SUB ? ~CI : CI;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage_g
      // RW: operand bits not yet consumed on entry; LW: result bits known on exit.
      localparam int RW = WIDTH - gi * CW;
      localparam int LW = (gi + 1) * CW;

      logic [RW-1:0] a_in;
      logic [RW-1:0] b_in;
      logic          carry_in;
      logic          valid_in;
      logic [CW:0]   sum;
      logic [LW-1:0] res_next;
      logic          valid_reg;
      logic          carry_reg;
      logic [LW-1:0] res_reg;

      assign sum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, carry_in};

      if (gi == 0) begin : src_g
        assign a_in     = A;
        assign b_in     = b_eff;
        assign carry_in = cin_eff;
        assign valid_in = in_valid;
        assign res_next = sum[CW-1:0];
      end else begin : src_g
        assign a_in     = stage_g[gi-1].pass_g.a_reg;
        assign b_in     = stage_g[gi-1].pass_g.b_reg;
        assign carry_in = stage_g[gi-1].carry_reg;
        assign valid_in = stage_g[gi-1].valid_reg;
        assign res_next = {sum[CW-1:0], stage_g[gi-1].res_reg};
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          res_reg   <= '0;
        end else begin
          valid_reg <= valid_in;
          if (valid_in) begin
            res_reg   <= res_next;
            carry_reg <= sum[CW];
          end
        end
      end

      if (gi < STAGES - 1) begin : pass_g
        // Upper operand chunks still waiting for their stage, shifted down to bit 0.
        logic [RW-CW-1:0] a_reg;
        logic [RW-CW-1:0] b_reg;

        always_ff @(posedge clk) begin
          if (!reset) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (valid_in) begin
            a_reg <= a_in[RW-1:CW];
            b_reg <= b_in[RW-1:CW];
          end
        end
      end else begin : out_g
        // Carry into the MSB is recovered from the MSB sum bit of the top chunk.
        logic msb_carry;
        logic v_reg;

        assign msb_carry = a_in[CW-1] ^ b_in[CW-1] ^ sum[CW-1];

        always_ff @(posedge clk) begin
          if (!reset) begin
            v_reg <= 1'b0;
          end else if (valid_in) begin
            v_reg <= msb_carry ^ sum[CW];
          end
        end
      end
    end
  endgenerate

  assign out_valid = stage_g[STAGES-1].valid_reg;
  assign O         = stage_g[STAGES-1].res_reg;
  assign C         = stage_g[STAGES-1].carry_reg;
  assign V         = stage_g[STAGES-1].out_g.v_reg;

endmodule
